// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes ID, carries control through EX/MEM/WB, stalls on data hazards, latches halt.
// Latency: ID -> ex_* 1 cycle, mem_* 2, wb_* 3; stall/decode combinational, everything else registered.
// Backpressure: stall holds ID and injects an EX bubble; `CTRL_FWD_EN` enables forwarding (load-use stall only).
module ctrl_pipe #(
    parameter int REG_AW = 4,
    parameter int OPC_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_vld,
    input  logic [OPC_W-1:0]  id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    output logic              stall,
    output logic              ex_alu_src,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_wr,
    output logic              ex_reg_wren,
    output logic              ex_branch,
    output logic [REG_AW-1:0] ex_dst,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic              mem_mem_to_reg,
    output logic              mem_mem_wr,
    output logic              mem_reg_wren,
    output logic [REG_AW-1:0] mem_dst,
    output logic              wb_mem_to_reg,
    output logic              wb_reg_wren,
    output logic [REG_AW-1:0] wb_dst,
    output logic              halt,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_XOR = 4'd2,  OP_RED = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4,  OP_SRA = 4'd5,  OP_ROR = 4'd6,  OP_PADDSB = 4'd7;
    localparam logic [3:0] OP_LW  = 4'd8,  OP_SW  = 4'd9,  OP_LHB = 4'd10, OP_LLB = 4'd11;
    localparam logic [3:0] OP_B   = 4'd12, OP_BR  = 4'd13, OP_PCS = 4'd14, OP_HLT = 4'd15;

    logic [3:0] op;
    logic       op_ok;
    logic       is_lw, is_sw, is_lhb, is_llb, is_b, is_br, is_pcs, is_hlt, is_shift;
    logic       uses_rs, uses_rt, hazard, live;
    logic       halt_pend, ex_hlt, mem_hlt;

    assign op = id_opcode[3:0];

    // Any nonzero bit above the decoded nibble makes the instruction invalid.
    generate
        if (OPC_W > 4) begin : g_opc_hi
            assign op_ok = (id_opcode[OPC_W-1:4] == '0);
        end else begin : g_opc_lo
            assign op_ok = 1'b1;
        end
    endgenerate

    function automatic logic src_hit(input logic [REG_AW-1:0] r,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt,
                                     input logic u_rs,
                                     input logic u_rt);
        return (r != '0) && ((u_rs && rs == r) || (u_rt && rt == r));
    endfunction

    always_comb begin
        is_lw    = (op == OP_LW);
        is_sw    = (op == OP_SW);
        is_lhb   = (op == OP_LHB);
        is_llb   = (op == OP_LLB);
        is_b     = (op == OP_B);
        is_br    = (op == OP_BR);
        is_pcs   = (op == OP_PCS);
        is_hlt   = (op == OP_HLT);
        is_shift = (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
        uses_rs  = !(is_b || is_lhb || is_llb || is_pcs || is_hlt);
        uses_rt  = (op inside {OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB}) || is_sw;
    end

    always_comb begin
        hazard = 1'b0;
`ifdef CTRL_FWD_EN
        hazard = ex_mem_to_reg && ex_reg_wren &&
                 src_hit(ex_dst, id_rs, id_rt, uses_rs, uses_rt);
`else
        // WB producers are covered by the register file's write-first half-cycle.
        hazard = (ex_reg_wren  && src_hit(ex_dst,  id_rs, id_rt, uses_rs, uses_rt)) ||
                 (mem_reg_wren && src_hit(mem_dst, id_rs, id_rt, uses_rs, uses_rt));
`endif
        stall = id_vld && !flush && hazard;
    end

    assign live = id_vld && !flush && !stall && !halt_pend && op_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_alu_src     <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
            ex_mem_wr      <= 1'b0;
            ex_reg_wren    <= 1'b0;
            ex_branch      <= 1'b0;
            ex_hlt         <= 1'b0;
            ex_dst         <= '0;
            ex_rs          <= '0;
            ex_rt          <= '0;
            mem_mem_to_reg <= 1'b0;
            mem_mem_wr     <= 1'b0;
            mem_reg_wren   <= 1'b0;
            mem_hlt        <= 1'b0;
            mem_dst        <= '0;
            wb_mem_to_reg  <= 1'b0;
            wb_reg_wren    <= 1'b0;
            wb_dst         <= '0;
            halt_pend      <= 1'b0;
            halt           <= 1'b0;
        end else begin
            ex_alu_src     <= live && (is_lw || is_sw || is_shift || is_lhb || is_llb);
            ex_mem_to_reg  <= live && is_lw;
            ex_mem_wr      <= live && is_sw;
            ex_reg_wren    <= live && (!op[3] || is_lw || is_lhb || is_llb || is_pcs);
            ex_branch      <= live && (is_b || is_br);
            ex_hlt         <= live && is_hlt;
            ex_dst         <= live ? (is_lw ? id_rt : id_rd) : '0;
            ex_rs          <= live ? id_rs : '0;
            ex_rt          <= live ? id_rt : '0;
            mem_mem_to_reg <= ex_mem_to_reg;
            mem_mem_wr     <= ex_mem_wr;
            mem_reg_wren   <= ex_reg_wren;
            mem_hlt        <= ex_hlt;
            mem_dst        <= ex_dst;
            wb_mem_to_reg  <= mem_mem_to_reg;
            wb_reg_wren    <= mem_reg_wren;
            wb_dst         <= mem_dst;
            halt_pend      <= halt_pend || (live && is_hlt);
            halt           <= halt || mem_hlt;
        end
    end

`ifdef CTRL_FWD_EN
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_reg_wren && mem_dst != '0 && mem_dst == ex_rs)
            fwd_a = 2'b10;
        else if (wb_reg_wren && wb_dst != '0 && wb_dst == ex_rs)
            fwd_a = 2'b01;
        if (mem_reg_wren && mem_dst != '0 && mem_dst == ex_rt)
            fwd_b = 2'b10;
        else if (wb_reg_wren && wb_dst != '0 && wb_dst == ex_rt)
            fwd_b = 2'b01;
    end
`else
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed hazard/flush/halt/reset cases plus random instruction streams
// compared cycle by cycle against an instruction-level pipeline model.
module tb_ctrl_pipe;

    localparam logic [3:0] O_ADD = 4'd0,  O_SUB = 4'd1,  O_XOR = 4'd2,  O_RED = 4'd3;
    localparam logic [3:0] O_SLL = 4'd4,  O_SRA = 4'd5,  O_ROR = 4'd6,  O_PADDSB = 4'd7;
    localparam logic [3:0] O_LW  = 4'd8,  O_SW  = 4'd9,  O_LHB = 4'd10, O_LLB = 4'd11;
    localparam logic [3:0] O_B   = 4'd12, O_BR  = 4'd13, O_PCS = 4'd14, O_HLT = 4'd15;

`ifdef CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       id_vld = 1'b0, flush = 1'b0;
    logic [3:0] id_opcode = '0, id_rs = '0, id_rt = '0, id_rd = '0;
    logic       stall, ex_alu_src, ex_mem_to_reg, ex_mem_wr, ex_reg_wren, ex_branch;
    logic [3:0] ex_dst, ex_rs, ex_rt, mem_dst, wb_dst;
    logic       mem_mem_to_reg, mem_mem_wr, mem_reg_wren, wb_mem_to_reg, wb_reg_wren, halt;
    logic [1:0] fwd_a, fwd_b;

    ctrl_pipe #(.REG_AW(4), .OPC_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_vld(id_vld), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .stall(stall),
        .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_wr(ex_mem_wr),
        .ex_reg_wren(ex_reg_wren), .ex_branch(ex_branch), .ex_dst(ex_dst),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_mem_wr(mem_mem_wr), .mem_reg_wren(mem_reg_wren), .mem_dst(mem_dst),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_wren(wb_reg_wren), .wb_dst(wb_dst),
        .halt(halt), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction-level model: each stage holds the original instruction or a bubble (v=0).
    typedef struct {
        bit         v;
        logic [3:0] op, rs, rt, rd;
    } ins_t;

    ins_t m_ex, m_mem, m_wb;
    bit   m_hpend, m_halt;
    bit   obs_stall, obs_halt, obs_ex_wr, obs_ex_mw;
    logic [1:0] obs_fwd_a, obs_fwd_b;

    function automatic ins_t bubble();
        ins_t b;
        b.v = 1'b0; b.op = '0; b.rs = '0; b.rt = '0; b.rd = '0;
        return b;
    endfunction

    function automatic bit m_wr(ins_t i);
        return i.v && (i.op < 4'd8 || i.op inside {O_LW, O_LHB, O_LLB, O_PCS});
    endfunction
    function automatic logic [3:0] m_dst(ins_t i);
        if (!i.v) return 4'd0;
        return (i.op == O_LW) ? i.rt : i.rd;
    endfunction
    function automatic bit m_reads(ins_t i, logic [3:0] r);
        bit u_rs, u_rt;
        u_rs = !(i.op inside {O_B, O_LHB, O_LLB, O_PCS, O_HLT});
        u_rt = i.op inside {O_ADD, O_SUB, O_XOR, O_RED, O_PADDSB, O_SW};
        return (r != 4'd0) && ((u_rs && i.rs == r) || (u_rt && i.rt == r));
    endfunction
    function automatic bit m_stall(ins_t id, bit fl);
        if (!id.v || fl) return 1'b0;
        if (FWD)
            return m_ex.v && m_ex.op == O_LW && m_reads(id, m_dst(m_ex));
        return (m_wr(m_ex) && m_reads(id, m_dst(m_ex))) ||
               (m_wr(m_mem) && m_reads(id, m_dst(m_mem)));
    endfunction
    function automatic logic [1:0] m_fwd(logic [3:0] r);
        if (!FWD) return 2'b00;
        if (m_wr(m_mem) && m_dst(m_mem) != 0 && m_dst(m_mem) == r) return 2'b10;
        if (m_wr(m_wb) && m_dst(m_wb) != 0 && m_dst(m_wb) == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check_outputs(input bit exp_stall);
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("ex_alu_src", 32'(ex_alu_src),
            32'(m_ex.v && (m_ex.op inside {O_LW, O_SW, O_SLL, O_SRA, O_ROR, O_LHB, O_LLB})));
        chk("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(m_ex.v && m_ex.op == O_LW));
        chk("ex_mem_wr", 32'(ex_mem_wr), 32'(m_ex.v && m_ex.op == O_SW));
        chk("ex_reg_wren", 32'(ex_reg_wren), 32'(m_wr(m_ex)));
        chk("ex_branch", 32'(ex_branch), 32'(m_ex.v && (m_ex.op == O_B || m_ex.op == O_BR)));
        chk("ex_dst", 32'(ex_dst), 32'(m_dst(m_ex)));
        chk("ex_rs", 32'(ex_rs), 32'(m_ex.v ? m_ex.rs : 4'd0));
        chk("ex_rt", 32'(ex_rt), 32'(m_ex.v ? m_ex.rt : 4'd0));
        chk("mem_mem_to_reg", 32'(mem_mem_to_reg), 32'(m_mem.v && m_mem.op == O_LW));
        chk("mem_mem_wr", 32'(mem_mem_wr), 32'(m_mem.v && m_mem.op == O_SW));
        chk("mem_reg_wren", 32'(mem_reg_wren), 32'(m_wr(m_mem)));
        chk("mem_dst", 32'(mem_dst), 32'(m_dst(m_mem)));
        chk("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(m_wb.v && m_wb.op == O_LW));
        chk("wb_reg_wren", 32'(wb_reg_wren), 32'(m_wr(m_wb)));
        chk("wb_dst", 32'(wb_dst), 32'(m_dst(m_wb)));
        chk("halt", 32'(halt), 32'(m_halt));
        chk("fwd_a", 32'(fwd_a), 32'(m_fwd(m_ex.v ? m_ex.rs : 4'd0)));
        chk("fwd_b", 32'(fwd_b), 32'(m_fwd(m_ex.v ? m_ex.rt : 4'd0)));
    endtask

    // One clock: drive ID, check at negedge, advance the model at posedge.
    task automatic step(input bit v, input logic [3:0] op, input logic [3:0] rs,
                        input logic [3:0] rt, input logic [3:0] rd, input bit fl);
        ins_t id, nx;
        bit   st, live;
        id_vld = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
        id.v = v; id.op = op; id.rs = rs; id.rt = rt; id.rd = rd;
        @(negedge clk);
        st = m_stall(id, fl);
        check_outputs(st);
        obs_stall = stall; obs_halt = halt; obs_ex_wr = ex_reg_wren; obs_ex_mw = ex_mem_wr;
        obs_fwd_a = fwd_a; obs_fwd_b = fwd_b;
        live = v && !fl && !st && !m_hpend;
        nx = live ? id : bubble();
        @(posedge clk);
        if (m_mem.v && m_mem.op == O_HLT) m_halt = 1'b1;
        if (live && op == O_HLT) m_hpend = 1'b1;
        m_wb = m_mem; m_mem = m_ex; m_ex = nx;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    endtask

    // Asserts reset mid-cycle and checks that everything clears without a clock edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_ex_wren"}, 32'(ex_reg_wren), 32'd0);
        chk({tag, "_ex_dst"}, 32'(ex_dst), 32'd0);
        chk({tag, "_mem_wren"}, 32'(mem_reg_wren), 32'd0);
        chk({tag, "_wb_wren"}, 32'(wb_reg_wren), 32'd0);
        chk({tag, "_halt"}, 32'(halt), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_fwd"}, 32'({fwd_a, fwd_b}), 32'd0);
        m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
        m_hpend = 1'b0; m_halt = 1'b0; obs_stall = 1'b0;
        @(negedge clk);
        id_vld = 1'b0; flush = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Holds a dependent instruction in ID until it goes live; returns the stall cycles seen.
    task automatic issue_dep(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                             input logic [3:0] rd, output int nst);
        nst = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, op, rs, rt, rd, 1'b0);
            if (k > 0) chk("stall_bubble_ex", 32'(obs_ex_wr), 32'd0);
            if (!obs_stall) break;
            nst++;
        end
    endtask

    int         nst;
    bit         r_v, r_fl;
    logic [3:0] r_op, r_rs, r_rt, r_rd;

    initial begin
        m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
        m_hpend = 1'b0; m_halt = 1'b0; obs_stall = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ex_wren", 32'(ex_reg_wren), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        // Load-use: LW r2 then ADD r4,r2,r5.
        step(1'b1, O_LW, 4'd1, 4'd2, 4'd0, 1'b0);
        issue_dep(O_ADD, 4'd2, 4'd5, 4'd4, nst);
        chk("lu_stall_cycles", 32'(nst), FWD ? 32'd1 : 32'd2);
        idle(1);
        chk("lu_fwd_a", 32'(obs_fwd_a), FWD ? 32'd1 : 32'd0);
        idle(3);

        // ALU-use: ADD r1 then SUB r6,r1,r1.
        step(1'b1, O_ADD, 4'd2, 4'd3, 4'd1, 1'b0);
        issue_dep(O_SUB, 4'd1, 4'd1, 4'd6, nst);
        chk("alu_stall_cycles", 32'(nst), FWD ? 32'd0 : 32'd2);
        idle(1);
        chk("alu_fwd_a", 32'(obs_fwd_a), FWD ? 32'd2 : 32'd0);
        chk("alu_fwd_b", 32'(obs_fwd_b), FWD ? 32'd2 : 32'd0);
        idle(3);

        // Writes to r0 never create hazards.
        step(1'b1, O_ADD, 4'd2, 4'd3, 4'd0, 1'b0);
        issue_dep(O_XOR, 4'd0, 4'd0, 4'd7, nst);
        chk("r0_stall_cycles", 32'(nst), 32'd0);
        idle(1);
        chk("r0_fwd", 32'({obs_fwd_a, obs_fwd_b}), 32'd0);
        idle(3);

        // Flush wins over a concurrent load-use match.
        step(1'b1, O_LW, 4'd1, 4'd3, 4'd0, 1'b0);
        step(1'b1, O_SW, 4'd3, 4'd4, 4'd0, 1'b1);
        chk("flush_stall", 32'(obs_stall), 32'd0);
        idle(1);
        chk("flush_ex_mem_wr", 32'(obs_ex_mw), 32'd0);
        chk("flush_ex_wren", 32'(obs_ex_wr), 32'd0);
        idle(3);

        // HLT then ADD r1: ADD bubbled, halt rises 3 cycles after HLT in ID.
        step(1'b1, O_HLT, 4'd0, 4'd0, 4'd0, 1'b0);
        step(1'b1, O_ADD, 4'd2, 4'd3, 4'd1, 1'b0);
        idle(1);
        chk("hlt_add_bubbled", 32'(obs_ex_wr), 32'd0);
        chk("hlt_early", 32'(obs_halt), 32'd0);
        idle(1);
        chk("hlt_rise", 32'(obs_halt), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1, O_ADD, 4'd1, 4'd2, 4'd3, 1'b0);
        chk("hlt_sticky", 32'(obs_halt), 32'd1);
        do_reset("hlt_rst");

        // Reset with ADD r3 in EX.
        step(1'b1, O_ADD, 4'd1, 4'd2, 4'd3, 1'b0);
        chk("pre_rst_ex_dst", 32'(ex_dst), 32'd3);
        do_reset("mid_rst");

        // Random streams on a small register window to provoke hazards.
        r_v = 1'b0; r_fl = 1'b0; r_op = '0; r_rs = '0; r_rt = '0; r_rd = '0;
        for (int c = 0; c < 600; c++) begin
            if (c % 150 == 149) do_reset("rnd_rst");
            if (!obs_stall) begin
                r_v  = ($urandom_range(0, 3) != 0);
                r_op = 4'($urandom_range(0, 14));
                if ($urandom_range(0, 59) == 0) r_op = O_HLT;
                r_rs = 4'($urandom_range(0, 3));
                r_rt = 4'($urandom_range(0, 3));
                r_rd = 4'($urandom_range(0, 3));
                r_fl = ($urandom_range(0, 7) == 0);
            end
            step(r_v, r_op, r_rs, r_rt, r_rd, r_fl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised pipelined control unit for the 5-stage core. It decodes the 4-bit opcode in ID and carries the resulting control bits and destination register through the EX, MEM and WB pipeline registers. It detects data hazards and generates a stall, squashes flushed instructions into bubbles, and latches a sticky halt. It replaces the purely combinational decoder, and the datapath stage registers no longer hold control bits.

## Interface
Parameters:
- REG_AW, 4, register-address width; register 0 is hardwired zero and never creates a hazard
- OPC_W, 4, opcode width; only the low 4 bits are decoded, and upper bits must be 0 for a valid instruction

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_vld  in  1  the ID-stage instruction is valid
- id_opcode  in  OPC_W  ID opcode
- id_rs, id_rt, id_rd  in  REG_AW  ID register fields
- flush  in  1  kills the ID instruction (branch taken)
- stall  out  1  hold PC and IF/ID; a bubble enters EX
- ex_alu_src, ex_mem_to_reg, ex_mem_wr, ex_reg_wren, ex_branch  out  1 each  EX control bits
- ex_dst, ex_rs, ex_rt  out  REG_AW  EX register fields
- mem_mem_to_reg, mem_mem_wr, mem_reg_wren  out  1 each  MEM control bits
- mem_dst  out  REG_AW  MEM destination register
- wb_mem_to_reg, wb_reg_wren  out  1 each  WB control bits
- wb_dst  out  REG_AW  WB destination register
- halt  out  1  sticky; set when HLT retires from WB
- fwd_a, fwd_b  out  2 each  forwarding selects for the EX operands

## Operation
- Opcode encodings:
  - 0–7: ADD, SUB, XOR, RED, SLL, SRA, ROR, PADDSB
  - 8–15: LW, SW, LHB, LLB, B, BR, PCS, HLT
- Decode: reg_wren = (~op[3] | LW | LHB | LLB | PCS) & live.
- Decode: mem_to_reg = LW; mem_wr = SW & live; branch = (B | BR) & live.
- Decode: alu_src = LW | SW | SLL | SRA | ROR | LHB | LLB.
- Decode: dst = rt for LW, rd otherwise.
- live = id_vld & ~flush & ~stall & ~halt_pend.
- uses_rt: opcodes ADD, SUB, XOR, RED, PADDSB and SW. Every opcode except B, LHB, LLB, PCS and HLT uses rs.
- Bubble: all write/enable bits 0 and all register fields 0.
- halt_pend sets when a live HLT enters EX. After that, every later ID instruction becomes a bubble. HLT writes nothing.
- halt rises when the HLT reaches WB. Only reset clears it.
- Stall condition (with forwarding): id_vld & ~flush & ex_mem_to_reg & ex_reg_wren & ex_dst≠0, and ex_dst matches a used ID source (rs, or rt when uses_rt).
- fwd_x = 2'b10 when mem_reg_wren & mem_dst≠0 & mem_dst == ex_rs (fwd_a) or ex_rt (fwd_b).
- Otherwise fwd_x = 2'b01 on the same test against WB.
- Otherwise fwd_x = 2'b00. MEM has priority over WB.
- flush and stall in the same cycle: flush wins and stall is forced to 0.

## Timing
- Decode and stall are combinational from ID inputs and EX/MEM state. Everything else is registered.
- An instruction live in ID in cycle n appears on ex_* in cycle n+1, mem_* in n+2 and wb_* in n+3.
- During stall, a bubble is written into EX; MEM and WB advance normally. The upstream logic holds the ID inputs stable.
- Reset asserted, including mid-pipeline: all stage registers clear to bubble immediately. halt = 0, halt_pend = 0, stall = 0, fwd_a = fwd_b = 0.
- Reset releases asynchronously; the first capture happens on the first clk edge after rst_n goes high.

## Configuration
- CTRL_FWD_EN defined: forwarding active as above; the stall covers load-use only (one bubble).
- CTRL_FWD_EN undefined: fwd_a and fwd_b are tied to 2'b00. stall asserts whenever a used ID source equals ex_dst (ex_reg_wren) or mem_dst (mem_reg_wren), nonzero.
- Undefined case: the register file writes in the first half-cycle, so a WB producer needs no stall. A dependent instruction stalls up to 2 cycles.

## Test plan
- Reset mid-stream: ADD r3 in ID, then assert rst_n = 0 → all ex/mem/wb outputs 0, halt = 0 in the same cycle.
- LW r2 then ADD r4,r2,r5 (FWD_EN) → stall = 1 for exactly one cycle with ex_reg_wren = 0 bubble. Then fwd_a = 2'b10... correction: fwd_a = 2'b01 when ADD is in EX.
- ADD r1, then SUB r6,r1,r1 (FWD_EN) → no stall; fwd_a = fwd_b = 2'b10 with SUB in EX.
- Same pair without FWD_EN → stall high for 2 cycles; SUB reaches EX 3 cycles after ADD.
- Writes to r0 (ADD r0 then XOR r7,r0,r0) → no stall, fwd = 00.
- flush with SW in ID and concurrent load-use match → stall = 0, EX receives a bubble with mem_wr = 0.
- HLT followed by ADD r1 → ADD is bubbled; halt rises 3 cycles after HLT is in ID and stays high until reset.
